// File: rtl/cute_fetch.sv
// cute_fetch: instruction fetch/sequencer feeding the cute core's DIN/Run inputs.
// Holds a 2**ADDR_W x 9 program store, issues one- and two-word instructions,
// and advances the PC on the core's done/jmp handshake.
// Optional feature: define CUTE_FETCH_WDOG_EN to enable the WAIT watchdog,
// which faults and halts after WDOG_CYC cycles in WAIT without done.
module cute_fetch #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [2:0]  OP_MVI    = 3'b001,
    parameter logic [2:0]  OP_JMP    = 3'b110,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
`ifdef CUTE_FETCH_WDOG_EN
   ,parameter int unsigned WDOG_CYC  = 16
`endif
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              go,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [8:0]        prog_data,
    input  logic              done,
    input  logic              jmp,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          mem_q [DEPTH];
    logic [8:0]          din_q, din_d;
    logic                run_q, run_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic                two_q, two_d;
    logic                fault_q, fault_d;
`ifdef CUTE_FETCH_WDOG_EN
    logic [15:0]         wdog_q, wdog_d;
`endif

    logic                store_open;
    logic [8:0]          w0, w1;
    logic                w0_two;
    logic [ADDR_W:0]     seq_pc;

    assign store_open = (state_q == S_IDLE) || (state_q == S_HALT);
    assign w0         = mem_q[pc_q];
    assign w1         = mem_q[pc_q + ADDR_W'(1)];
    assign w0_two     = (w0[8:6] == OP_MVI) || (w0[8:6] == OP_JMP);
    // one extra bit so running off the end of the store shows up as a carry
    assign seq_pc     = {1'b0, pc_q} + (two_q ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

    // program store write port; closed while executing and during reset
    always_ff @(posedge clk) begin
        if (Resetn && prog_we && store_open) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            run_q   <= 1'b0;
            pc_q    <= '0;
            tgt_q   <= '0;
            two_q   <= 1'b0;
            fault_q <= 1'b0;
`ifdef CUTE_FETCH_WDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            two_q   <= two_d;
            fault_q <= fault_d;
`ifdef CUTE_FETCH_WDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // sequencing: next state, DIN/Run drive, PC update and fault detection
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        run_d   = 1'b0;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        two_d   = two_q;
        fault_d = fault_q;
`ifdef CUTE_FETCH_WDOG_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (go) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    fault_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (w0 == HALT_WORD) begin
                    state_d = S_HALT;
                    din_d   = '0;
                end else if (w0_two && (pc_q == '1)) begin
                    // word1 would lie past the store end: refuse to issue
                    state_d = S_HALT;
                    din_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    din_d   = w0;
                    run_d   = 1'b1;
                    two_d   = w0_two;
                end
            end
            S_ISSUE: begin
                if (two_q) begin
                    state_d = S_IMM;
                    din_d   = w1;
                end else begin
                    state_d = S_WAIT;
`ifdef CUTE_FETCH_WDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            S_IMM: begin
                state_d = S_WAIT;
                tgt_d   = din_q[ADDR_W-1:0];
`ifdef CUTE_FETCH_WDOG_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (done) begin
                    if (two_q && jmp) begin
                        state_d = S_FETCH;
                        pc_d    = tgt_q;
                    end else if (seq_pc[ADDR_W]) begin
                        state_d = S_HALT;
                        din_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = seq_pc[ADDR_W-1:0];
                    end
                end
`ifdef CUTE_FETCH_WDOG_EN
                else if (wdog_q == 16'(WDOG_CYC - 1)) begin
                    state_d = S_HALT;
                    din_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DIN    = din_q;
    assign Run    = run_q;
    assign pc     = pc_q;
    assign busy   = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;

endmodule
